sync_fifo_param: RTL and testbench

//  Single-clock, parametrised FIFO: the general-purpose successor to the team's dual-clock FIFO for same-domain buffering.

---
 rtl/fifo_pkg.sv | 15 +
 rtl/fifo_mem_dp.sv | 22 ++
 rtl/sync_fifo_param.sv | 96 +++++++++
 tb/tb_sync_fifo_param.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO helpers (address sizing and explicit pointer wrap for any depth).
package fifo_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v * 2) r++;
        return r;
    endfunction

    function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input int depth);
        return (ptr == 32'(depth - 1)) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// fifo_mem_dp: WIDTH x DEPTH storage, synchronous write, asynchronous read, no reset.
module fifo_mem_dp #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int PTR_WIDTH = 4
) (
    input  logic                 clk_i,
    input  logic                 we,
    input  logic [PTR_WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic [PTR_WIDTH-1:0] raddr,
    output logic [WIDTH-1:0]     rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_i)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with count, almost flags, flush and overflow/underflow pulses.
// Define SYNC_FIFO_FWFT_EN for first-word fall-through reads; default is a registered 1-cycle read.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int PTR_WIDTH = 4,
    parameter int AF_LEVEL  = DEPTH - 2,
    parameter int AE_LEVEL  = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 wr_en_i,
    input  logic [WIDTH-1:0]     wdata_i,
    output logic                 full_o,
    output logic                 almost_full_o,
    input  logic                 rd_en_i,
    output logic [WIDTH-1:0]     rdata_o,
    output logic                 rvalid_o,
    output logic                 empty_o,
    output logic                 almost_empty_o,
    output logic [PTR_WIDTH:0]   count_o,
    output logic                 overflow_o,
    output logic                 underflow_o
);

    localparam int CW = PTR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    if (PTR_WIDTH != clog2(DEPTH)) begin : g_ptr_check
        $error("sync_fifo_param: PTR_WIDTH must equal clog2(DEPTH)");
    end

    logic [PTR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [WIDTH-1:0]     mem_rdata;
    logic                 wr_acc, rd_acc;
    logic [CW-1:0]        count_next;

    assign rd_acc     = rd_en_i & ~empty_o;
    assign wr_acc     = wr_en_i & (~full_o | rd_acc);
    assign count_next = count_o + CW'(wr_acc) - CW'(rd_acc);

    fifo_mem_dp #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_WIDTH(PTR_WIDTH)) u_mem (
        .clk_i (clk_i),
        .we    (wr_acc & ~rst_i & ~flush_i),
        .waddr (wr_ptr),
        .wdata (wdata_i),
        .raddr (rd_ptr),
        .rdata (mem_rdata)
    );

    // Flags are registered from the next-state count so they line up with count_o.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count_o        <= '0;
            empty_o        <= 1'b1;
            almost_empty_o <= 1'b1;
            full_o         <= 1'b0;
            almost_full_o  <= (AF_LEVEL == 0);
            overflow_o     <= 1'b0;
            underflow_o    <= 1'b0;
        end else begin
            wr_ptr         <= wr_acc ? PTR_WIDTH'(ptr_inc(32'(wr_ptr), DEPTH)) : wr_ptr;
            rd_ptr         <= rd_acc ? PTR_WIDTH'(ptr_inc(32'(rd_ptr), DEPTH)) : rd_ptr;
            count_o        <= count_next;
            empty_o        <= (count_next == '0);
            almost_empty_o <= (count_next <= AE_C);
            full_o         <= (count_next == DEPTH_C);
            almost_full_o  <= (count_next >= AF_C);
            overflow_o     <= wr_en_i & ~wr_acc;
            underflow_o    <= rd_en_i & ~rd_acc;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign rdata_o  = mem_rdata;
    assign rvalid_o = ~empty_o;
`else
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_o  <= '0;
            rvalid_o <= 1'b0;
        end else begin
            rdata_o  <= (rd_acc && !flush_i) ? mem_rdata : rdata_o;
            rvalid_o <= rd_acc & ~flush_i;
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed checks of the FIFO at DEPTH=16 (main) and DEPTH=12 (wrap).
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       rst, flush, wr_en, rd_en;
    logic [7:0] wdata, rdata;
    logic       full, af, rvalid, empty, ae, ovf, udf;
    logic [4:0] count;

    logic       b_wr_en, b_rd_en;
    logic [7:0] b_wdata, b_rdata;
    logic       b_full, b_af, b_rvalid, b_empty, b_ae, b_ovf, b_udf;
    logic [4:0] b_count;

    int vec = 0;
    int errs = 0;

    always #5 clk = ~clk;

    sync_fifo_param #(.WIDTH(8), .DEPTH(16), .PTR_WIDTH(4)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .wr_en_i(wr_en), .wdata_i(wdata),
        .full_o(full), .almost_full_o(af), .rd_en_i(rd_en), .rdata_o(rdata),
        .rvalid_o(rvalid), .empty_o(empty), .almost_empty_o(ae), .count_o(count),
        .overflow_o(ovf), .underflow_o(udf)
    );

    sync_fifo_param #(.WIDTH(8), .DEPTH(12), .PTR_WIDTH(4)) dut12 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .wr_en_i(b_wr_en), .wdata_i(b_wdata),
        .full_o(b_full), .almost_full_o(b_af), .rd_en_i(b_rd_en), .rdata_o(b_rdata),
        .rvalid_o(b_rvalid), .empty_o(b_empty), .almost_empty_o(b_ae), .count_o(b_count),
        .overflow_o(b_ovf), .underflow_o(b_udf)
    );

    // {full, almost_full, empty, almost_empty, overflow, underflow, rvalid}
    logic [6:0] fl;
    assign fl = {full, af, empty, ae, ovf, udf, rvalid};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; flush = 0; wr_en = 0; rd_en = 0; wdata = 0;
        b_wr_en = 0; b_rd_en = 0; b_wdata = 0;
        tick();
        tick();
        rst = 0;
        vec++;
        if (fl !== 7'b0011000 || count !== 5'd0) begin
            errs++;
            $display("FAIL reset flags=%b count=%0d expected flags=0011000 count=0", fl, count);
        end
`ifndef SYNC_FIFO_FWFT_EN
        vec++;
        if (rdata !== 8'h00) begin
            errs++;
            $display("FAIL reset_rdata got %h expected 00", rdata);
        end
`endif
    endtask

    task automatic test_fill_overflow();
        for (int i = 1; i <= 16; i++) begin
            wr_en = 1; wdata = 8'(i);
            tick();
            vec++;
            if (count !== 5'(i) || fl !== {i == 16, i >= 14, 1'b0, i <= 2, 3'b000}) begin
                errs++;
                $display("FAIL fill_%0d count=%0d flags=%b", i, count, fl);
            end
        end
        wdata = 8'h11;
        tick();
        vec++;
        if (count !== 5'd16 || fl !== 7'b1100100) begin
            errs++;
            $display("FAIL overflow count=%0d flags=%b expected 16 1100100", count, fl);
        end
        wr_en = 0;
        tick();
        vec++;
        if (ovf !== 1'b0) begin
            errs++;
            $display("FAIL overflow_pulse_len got %b expected 0", ovf);
        end
    endtask

    task automatic test_drain_underflow();
        rd_en = 1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            vec++;
            if (rdata !== 8'(i) || count !== 5'(16 - i) ||
                fl !== {1'b0, (16 - i) >= 14, i == 16, (16 - i) <= 2, 3'b001}) begin
                errs++;
                $display("FAIL drain_%0d rdata=%h count=%0d flags=%b expected rdata=%h", i, rdata, count, fl, 8'(i));
            end
        end
        tick();
        vec++;
        if (fl !== 7'b0011010 || rdata !== 8'h10 || count !== 5'd0) begin
            errs++;
            $display("FAIL underflow flags=%b rdata=%h count=%0d expected 0011010 10 0", fl, rdata, count);
        end
        rd_en = 0;
        tick();
        vec++;
        if (udf !== 1'b0) begin
            errs++;
            $display("FAIL underflow_pulse_len got %b expected 0", udf);
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] exp_q[$];
        for (int i = 0; i < 16; i++) begin
            wr_en = 1; wdata = 8'(8'h20 + i);
            exp_q.push_back(wdata);
            tick();
        end
        rd_en = 1; wdata = 8'hEE;
        exp_q.push_back(8'hEE);
        tick();
        vec++;
        if (ovf !== 1'b0 || count !== 5'd16 || full !== 1'b1 || rvalid !== 1'b1 || rdata !== 8'h20) begin
            errs++;
            $display("FAIL full_wr_rd ovf=%b count=%0d full=%b rvalid=%b rdata=%h expected 0 16 1 1 20",
                     ovf, count, full, rvalid, rdata);
        end
        void'(exp_q.pop_front());
        wr_en = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            vec++;
            if (rdata !== exp_q[i] || rvalid !== 1'b1) begin
                errs++;
                $display("FAIL full_drain_%0d rdata=%h rvalid=%b expected %h", i, rdata, rvalid, exp_q[i]);
            end
        end
        wr_en = 1; rd_en = 1; wdata = 8'h77;
        tick();
        vec++;
        if (udf !== 1'b1 || ovf !== 1'b0 || count !== 5'd1 || empty !== 1'b0) begin
            errs++;
            $display("FAIL empty_wr_rd udf=%b ovf=%b count=%0d empty=%b expected 1 0 1 0", udf, ovf, count, empty);
        end
        wr_en = 0;
        tick();
        vec++;
        if (rdata !== 8'h77 || count !== 5'd0 || rvalid !== 1'b1) begin
            errs++;
            $display("FAIL empty_wr_rd_pop rdata=%h count=%0d rvalid=%b expected 77 0 1", rdata, count, rvalid);
        end
        rd_en = 0;
        tick();
    endtask

    task automatic test_wrap12();
        logic [7:0] q[$];
        logic [7:0] exp_d;
        logic       rda, wra, e_ovf, e_udf;
        int         nw;
        nw = 0;
        for (int k = 0; k < 80; k++) begin
            b_wr_en = (k % 4 != 3) && (nw < 40);
            b_rd_en = (k % 2 == 1) || (nw >= 40);
            b_wdata = 8'(8'h40 + nw);
            rda = b_rd_en && (q.size() > 0);
            wra = b_wr_en && (q.size() < 12 || rda);
            e_ovf = b_wr_en && !wra;
            e_udf = b_rd_en && !rda;
            exp_d = 8'h00;
            if (rda) exp_d = q.pop_front();
            if (wra) begin
                q.push_back(b_wdata);
                nw++;
            end
            tick();
            vec++;
            if (b_count !== 5'(q.size()) || {b_ovf, b_udf, b_rvalid} !== {e_ovf, e_udf, rda} ||
                (rda && b_rdata !== exp_d)) begin
                errs++;
                $display("FAIL wrap12_cyc%0d count=%0d ovf/udf/rvalid=%b%b%b rdata=%h expected count=%0d %b%b%b rdata=%h",
                         k, b_count, b_ovf, b_udf, b_rvalid, b_rdata, q.size(), e_ovf, e_udf, rda, exp_d);
            end
        end
        b_wr_en = 0; b_rd_en = 0;
        vec++;
        if (nw != 40 || b_empty !== 1'b1) begin
            errs++;
            $display("FAIL wrap12_end writes=%0d empty=%b expected 40 1", nw, b_empty);
        end
    endtask

    task automatic test_flush_reset();
        for (int i = 0; i < 9; i++) begin
            wr_en = 1; wdata = 8'(8'h50 + i);
            tick();
        end
        vec++;
        if (count !== 5'd9) begin
            errs++;
            $display("FAIL prefill count=%0d expected 9", count);
        end
        flush = 1; rd_en = 1; wdata = 8'h99;
        tick();
        flush = 0; wr_en = 0; rd_en = 0;
        vec++;
        if (count !== 5'd0 || fl !== 7'b0011000) begin
            errs++;
            $display("FAIL flush count=%0d flags=%b expected 0 0011000", count, fl);
        end
        for (int i = 0; i < 3; i++) begin
            wr_en = 1; wdata = 8'(8'h31 + i);
            tick();
        end
        wr_en = 0; rd_en = 1;
        tick();
        rd_en = 0;
        vec++;
        if (rdata !== 8'h31 || count !== 5'd2) begin
            errs++;
            $display("FAIL post_flush_read rdata=%h count=%0d expected 31 2", rdata, count);
        end
        rst = 1; wr_en = 1; rd_en = 1; wdata = 8'hCC;
        tick();
        rst = 0; wr_en = 0; rd_en = 0;
        vec++;
        if (count !== 5'd0 || fl !== 7'b0011000 || rdata !== 8'h00) begin
            errs++;
            $display("FAIL mid_reset count=%0d flags=%b rdata=%h expected 0 0011000 00", count, fl, rdata);
        end
    endtask

`ifdef SYNC_FIFO_FWFT_EN
    task automatic test_fwft();
        wr_en = 1; wdata = 8'hA5;
        tick();
        wr_en = 0;
        vec++;
        if (rvalid !== 1'b1 || rdata !== 8'hA5 || empty !== 1'b0) begin
            errs++;
            $display("FAIL fwft_show rvalid=%b rdata=%h empty=%b expected 1 a5 0", rvalid, rdata, empty);
        end
        rd_en = 1;
        tick();
        rd_en = 0;
        vec++;
        if (empty !== 1'b1 || rvalid !== 1'b0 || count !== 5'd0) begin
            errs++;
            $display("FAIL fwft_pop empty=%b rvalid=%b count=%0d expected 1 0 0", empty, rvalid, count);
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef SYNC_FIFO_FWFT_EN
        test_fwft();
`else
        test_fill_overflow();
        test_drain_underflow();
        test_simultaneous();
        test_wrap12();
        test_flush_reset();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
